// File: rtl/t01_board_sequencer.sv
// Settled-playfield owner for team 01: merges landed pieces, runs the
// line-clear engine, checks the spawn rows and requests the next piece.
module t01_board_sequencer #(
  parameter int TIMEOUT    = 64,
  parameter int SPAWN_ROWS = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   gamestate,
  input  logic         piece_landed,
  input  logic [199:0] piece_array,
  input  logic [599:0] piece_color_array,
  input  logic         spawn_ack,
  input  logic         lc_done,
  input  logic [199:0] lc_out_array,
  input  logic [599:0] lc_out_color_array,
  output logic         lc_start,
  output logic [199:0] lc_in_array,
  output logic [599:0] lc_in_color_array,
  output logic [199:0] board_array,
  output logic [599:0] board_color_array,
  output logic         spawn_req,
  output logic         busy,
  output logic         game_over,
  output logic         fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_CHECK,
    S_SPAWN,
    S_OVER
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [7:0]   cnt;
  logic [599:0] merge_color;
  logic         restart;
  logic         collide;
  logic         timed_out;
  logic         spawn_blocked;

  assign restart       = reset || (gamestate == 4'd9);
  assign collide       = |(piece_array & board_array);
  assign timed_out     = (cnt == 8'(TIMEOUT - 1));
  assign spawn_blocked = |board_array[10*SPAWN_ROWS-1:0];

  assign lc_in_array       = board_array;
  assign lc_in_color_array = board_color_array;

  always_comb begin
    merge_color = board_color_array;
    for (int i = 0; i < 200; i++) begin
      if (piece_array[i])
        merge_color[3*i+:3] = piece_color_array[3*i+:3];
    end
  end

  always_ff @(posedge clk) begin
    if (restart) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (piece_landed)
          state_nxt = collide ? S_OVER : S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:
        if (lc_done || timed_out)
          state_nxt = S_CHECK;
      S_CHECK:
        state_nxt = spawn_blocked ? S_OVER : S_SPAWN;
      S_SPAWN:
        if (spawn_ack)
          state_nxt = S_IDLE;
      S_OVER:  state_nxt = S_OVER;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    lc_start  = 1'b0;
    spawn_req = 1'b0;
    busy      = 1'b1;
    unique case (1'b1)
      (state == S_IDLE):  busy      = 1'b0;
      (state == S_START): lc_start  = 1'b1;
      (state == S_SPAWN): spawn_req = 1'b1;
      default: ;
    endcase
  end

  // Board only moves on the merge edge out of IDLE or a commit in WAIT
  always_ff @(posedge clk) begin
    if (restart) begin
      board_array       <= '0;
      board_color_array <= '0;
      cnt               <= '0;
      game_over         <= 1'b0;
      fault             <= 1'b0;
    end else begin
      if (piece_landed && state != S_IDLE)
        fault <= 1'b1;
      unique case (state)
        S_IDLE:
          if (piece_landed) begin
            if (collide) begin
              game_over <= 1'b1;
            end else begin
              board_array       <= board_array | piece_array;
              board_color_array <= merge_color;
            end
          end
        S_START: cnt <= '0;
        S_WAIT: begin
          cnt <= cnt + 8'd1;
          if (lc_done) begin
            board_array       <= lc_out_array;
            board_color_array <= lc_out_color_array;
          end else if (timed_out) begin
            fault <= 1'b1;
          end
        end
        S_CHECK:
          if (spawn_blocked)
            game_over <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
